// File: rtl/buzzer_score_ctrl.sv
// buzzer_score_ctrl
// Upstream controller for the scoreboard display driver. It debounces three
// team buzzers and three host buttons and locks out every team except the
// first one to buzz. It then applies the host's correct or wrong judgement
// to that team's two-digit BCD score.
//
// Ports:
//   clk_100MHz  system clock; all logic runs on the rising edge
//   rst_n       asynchronous active-low reset
//   btn_team    raw team buzzers (bit2 = A, bit1 = B, bit0 = C)
//   btn_start   raw host "arm round" button
//   btn_correct raw host "answer correct" button
//   btn_wrong   raw host "answer wrong" button
//   state       00 = IDLE, 01 = ARMED, 10 = LOCKED
//   ones, tens  BCD digits of the displayed team's score
//   thousands   one-hot displayed team (100 = A, 010 = B, 001 = C), 000 = none
module buzzer_score_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [2:0] btn_team,
    input  logic       btn_start,
    input  logic       btn_correct,
    input  logic       btn_wrong,
    output logic [1:0] state,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [2:0] thousands
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    localparam int NCH = 6;
    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    // Channel map: [5:3] = teams A/B/C, [2] = start, [1] = correct, [0] = wrong.
    logic [NCH-1:0]  raw;
    logic [NCH-1:0]  sync1_q, sync2_q, db_q, pulse_q;
    logic [DB_W-1:0] cnt_q [NCH];
    logic [NCH-1:0]  flip;

    assign raw = {btn_team, btn_start, btn_correct, btn_wrong};

    // A channel flips on the last cycle of its disagreement window. Every
    // channel goes through the same path, so raw-to-pulse latency is equal
    // and no team gains an edge from the order of the channels.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            flip[i] = (sync2_q[i] != db_q[i]) && (cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            pulse_q <= '0;
            // NOTE: these per-channel arrays are plain flops, not RAM, so they
            // are cleared here with everything else. This keeps the debouncers
            // from starting with a false "pressed" level.
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: every sequential assignment uses <=. All flops then sample
            // pre-edge values, and the two synchroniser stages really are two
            // separate stages.
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_q ^ flip;
            // A press pulse comes only from a 0 -> 1 flip. Releases are dropped.
            pulse_q <= flip & ~db_q;
            for (int i = 0; i < NCH; i++) begin
                if (sync2_q[i] == db_q[i] || flip[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Score arithmetic saturates at 99 and 00.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.tens == 4'd9 && v.ones == 4'd9) begin
            r = v;
        end else if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.tens == 4'd0 && v.ones == 4'd0) begin
            r = v;
        end else if (v.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = v.tens - 4'd1;
        end else begin
            r.ones = v.ones - 4'd1;
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] thousands_q, thousands_d;
    logic [3:0] ones_q, ones_d, tens_q, tens_d;
    bcd_t       score_q [3];
    bcd_t       score_d [3];

    logic [2:0] team_p, winner;
    bcd_t       win_score, cur_score, new_score;

    assign team_p = pulse_q[5:3];

    always_comb begin
        // NOTE: every variable gets its default before any branch. No path
        // leaves one unassigned, so no latch can be inferred.
        state_d     = state_q;
        thousands_d = thousands_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        score_d     = score_q;
        win_score   = '0;
        cur_score   = '0;
        new_score   = '0;

        // Fixed priority A > B > C for buzzes that land in the same cycle.
        if (team_p[2])      winner = 3'b100;
        else if (team_p[1]) winner = 3'b010;
        else                winner = 3'b001;

        for (int i = 0; i < 3; i++) begin
            if (winner[i])      win_score = score_q[i];
            if (thousands_q[i]) cur_score = score_q[i];
        end

        // Correct takes precedence when both judgement buttons arrive together.
        new_score = pulse_q[1] ? bcd_inc(cur_score) : bcd_dec(cur_score);

        case (state_q)
            ST_IDLE: begin
                if (pulse_q[2]) begin
                    state_d     = ST_ARMED;
                    thousands_d = 3'b000;
                    ones_d      = 4'd0;
                    tens_d      = 4'd0;
                end
            end
            ST_ARMED: begin
                if (|team_p) begin
                    state_d     = ST_LOCKED;
                    thousands_d = winner;
                    ones_d      = win_score.ones;
                    tens_d      = win_score.tens;
                end
            end
            ST_LOCKED: begin
                if (pulse_q[1] || pulse_q[0]) begin
                    state_d = ST_IDLE;
                    ones_d  = new_score.ones;
                    tens_d  = new_score.tens;
                    for (int i = 0; i < 3; i++) begin
                        if (thousands_q[i]) score_d[i] = new_score;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            thousands_q <= 3'b000;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            thousands_q <= thousands_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            score_q     <= score_d;
        end
    end

    assign state     = state_q;
    assign thousands = thousands_q;
    assign ones      = ones_q;
    assign tens      = tens_q;

endmodule

// File: tb/tb_buzzer_score_ctrl.sv
// Self-checking bench for buzzer_score_ctrl.
// The design runs with a short debounce window. Expected outputs are packed
// as {state, thousands, tens, ones}.
module tb_buzzer_score_ctrl;

    localparam int DB = 4;

    // Button masks: {A, B, C, start, correct, wrong}
    localparam logic [5:0] B_A   = 6'b100000;
    localparam logic [5:0] B_B   = 6'b010000;
    localparam logic [5:0] B_C   = 6'b001000;
    localparam logic [5:0] B_S   = 6'b000100;
    localparam logic [5:0] B_COR = 6'b000010;
    localparam logic [5:0] B_WR  = 6'b000001;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic [2:0] btn_team;
    logic       btn_start, btn_correct, btn_wrong;
    logic [1:0] state;
    logic [3:0] ones, tens;
    logic [2:0] thousands;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    buzzer_score_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DB_W           (3)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_team   (btn_team),
        .btn_start  (btn_start),
        .btn_correct(btn_correct),
        .btn_wrong  (btn_wrong),
        .state      (state),
        .ones       (ones),
        .tens       (tens),
        .thousands  (thousands)
    );

    typedef struct {
        string      name;
        logic [5:0] btn;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {state, thousands, tens, ones};
    endfunction

    function automatic logic [12:0] ex(input logic [1:0] s, input logic [2:0] th,
                                       input int tn, input int on);
        return {s, th, 4'(tn), 4'(on)};
    endfunction

    task automatic add(input string n, input logic [5:0] b, input logic [12:0] e);
        vec_t v;
        v.name = n;
        v.btn  = b;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] m);
        {btn_team, btn_start, btn_correct, btn_wrong} = m;
    endtask

    // Hold a button well past the debounce window, release it, and let the
    // release settle before the next press.
    task automatic press(input logic [5:0] m);
        @(negedge clk_100MHz);
        drive(m);
        repeat (DB + 4) @(negedge clk_100MHz);
        drive(6'b0);
        repeat (DB + 6) @(negedge clk_100MHz);
    endtask

    task automatic round(input logic [5:0] team, input logic [5:0] judge);
        press(B_S);
        press(team);
        press(judge);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(6'b0);
        repeat (3) @(negedge clk_100MHz);
        check("reset_outputs", 32'(outs()), 32'(ex(2'b00, 3'b000, 0, 0)));
        rst_n = 1'b1;

        add("team_in_idle",   B_B,         ex(2'b00, 3'b000, 0, 0));
        add("correct_idle",   B_COR,       ex(2'b00, 3'b000, 0, 0));
        add("arm1",           B_S,         ex(2'b01, 3'b000, 0, 0));
        add("correct_armed",  B_COR,       ex(2'b01, 3'b000, 0, 0));
        add("b_wins",         B_B,         ex(2'b10, 3'b010, 0, 0));
        add("start_locked",   B_S,         ex(2'b10, 3'b010, 0, 0));
        add("b_correct",      B_COR,       ex(2'b00, 3'b010, 0, 1));
        add("arm2",           B_S,         ex(2'b01, 3'b000, 0, 0));
        add("a_c_same_edge",  B_A | B_C,   ex(2'b10, 3'b100, 0, 0));
        add("late_c_ignored", B_C,         ex(2'b10, 3'b100, 0, 0));
        add("a_wrong_sat0",   B_WR,        ex(2'b00, 3'b100, 0, 0));
        add("arm3",           B_S,         ex(2'b01, 3'b000, 0, 0));
        add("c_wins",         B_C,         ex(2'b10, 3'b001, 0, 0));
        add("c_wrong_sat0",   B_WR,        ex(2'b00, 3'b001, 0, 0));
        add("arm4",           B_S,         ex(2'b01, 3'b000, 0, 0));
        add("b_wins_shows1",  B_B,         ex(2'b10, 3'b010, 0, 1));
        add("cor_wr_both",    B_COR | B_WR, ex(2'b00, 3'b010, 0, 2));

        foreach (vecs[i]) begin
            press(vecs[i].btn);
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // A two-cycle glitch on buzzer B while ARMED must not lock the round.
        press(B_S);
        @(negedge clk_100MHz);
        btn_team[1] = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        btn_team[1] = 1'b0;
        repeat (3 * DB) @(negedge clk_100MHz);
        check("glitch_ignored", 32'(outs()), 32'(ex(2'b01, 3'b000, 0, 0)));

        // Bring team A from 00 up to 09, then check the BCD carry to 10.
        press(B_A);
        press(B_COR);
        for (int i = 0; i < 8; i++) round(B_A, B_COR);
        press(B_S);
        press(B_A);
        check("a_shows_09", 32'(outs()), 32'(ex(2'b10, 3'b100, 0, 9)));
        press(B_COR);
        check("a_carry_10", 32'(outs()), 32'(ex(2'b00, 3'b100, 1, 0)));

        // Bring A up to 99. One more correct must saturate.
        for (int i = 0; i < 89; i++) round(B_A, B_COR);
        press(B_S);
        press(B_A);
        check("a_shows_99", 32'(outs()), 32'(ex(2'b10, 3'b100, 9, 9)));
        press(B_COR);
        check("a_sat_99", 32'(outs()), 32'(ex(2'b00, 3'b100, 9, 9)));

        // Bring C from 00 up to 10. A wrong answer must borrow down to 09.
        for (int i = 0; i < 10; i++) round(B_C, B_COR);
        press(B_S);
        press(B_C);
        check("c_shows_10", 32'(outs()), 32'(ex(2'b10, 3'b001, 1, 0)));
        press(B_WR);
        check("c_borrow_09", 32'(outs()), 32'(ex(2'b00, 3'b001, 0, 9)));

        // Apply an asynchronous reset mid-LOCKED, away from any clock edge.
        press(B_S);
        press(B_A);
        check("a_locked_99", 32'(outs()), 32'(ex(2'b10, 3'b100, 9, 9)));
        @(negedge clk_100MHz);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(outs()), 32'(ex(2'b00, 3'b000, 0, 0)));
        @(negedge clk_100MHz);
        rst_n = 1'b1;

        // Every team's score must have been cleared by the reset.
        press(B_S);
        press(B_A);
        check("a_cleared", 32'(outs()), 32'(ex(2'b10, 3'b100, 0, 0)));
        press(B_WR);
        press(B_S);
        press(B_B);
        check("b_cleared", 32'(outs()), 32'(ex(2'b10, 3'b010, 0, 0)));
        press(B_WR);
        press(B_S);
        press(B_C);
        check("c_cleared", 32'(outs()), 32'(ex(2'b10, 3'b001, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzzer_score_ctrl.md
Name: buzzer_score_ctrl

Overview:
- Upstream controller for the scoreboard display driver.
- Debounces three team buzzers and three host buttons, and locks out all but the first team to buzz.
- Applies the host's correct/wrong judgement to a per-team two-digit BCD score.
- Drives the display's state, ones, tens and one-hot team code (thousands).

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles an input must stay stable before its new level is accepted (10 ms at 100 MHz; bench overrides to 4).
- DB_W, 20, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk_100MHz  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_team  in  3  raw team buzzers, asynchronous; bit2=team A, bit1=team B, bit0=team C.
- btn_start  in  1  raw host "arm round" button.
- btn_correct  in  1  raw host "answer correct" button.
- btn_wrong  in  1  raw host "answer wrong" button.
- state  out  2  00=IDLE, 01=ARMED, 10=LOCKED; 11 never driven.
- ones  out  4  BCD ones digit of the displayed team's score.
- tens  out  4  BCD tens digit of the displayed team's score.
- thousands  out  3  one-hot displayed team (100=A, 010=B, 001=C); 000=none.

Behaviour:
- Reset (async assert, sync deassert use): state=00, thousands=000, ones=0, tens=0. All three scores=00, sync/debounce registers=0, edge pulses=0.
- Input path, identical for all 6 inputs:
  - 2-FF synchroniser, then per-input debounce counter.
  - Counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Rising edge of the debounced level produces a 1-cycle press pulse. Releases produce nothing.
  - Raw-to-pulse latency is fixed and equal on every channel, so priority is fair.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM (state register = state output):
  - IDLE: start pulse -> ARMED. Team, correct and wrong pulses are ignored.
  - On IDLE->ARMED, thousands<=000 and ones/tens<=0.
  - ARMED: the first cycle with any team pulse -> LOCKED, with thousands<=the one-hot winner.
  - Simultaneous pulses in the same cycle resolve by fixed priority A>B>C.
  - On that transition, ones/tens<=the winner's current score.
  - ARMED: start, correct and wrong pulses are ignored.
  - LOCKED: further team pulses and start pulses are ignored.
  - LOCKED, correct pulse: winner score +1 BCD (09->10, 19->20), saturating at 99; then -> IDLE.
  - LOCKED, wrong pulse: winner score -1 BCD (10->09), saturating at 00; then -> IDLE.
  - Correct and wrong pulses in the same cycle: correct wins.
  - On LOCKED->IDLE, thousands is held (it shows the last judged team) and ones/tens take the updated score in the same edge.
- All outputs are registered. The score change is visible one cycle after the judgement pulse.
- ones and tens are always valid BCD 0-9.
- thousands is always 000 or exactly one hot.
- A buzzer held from before ARMED does not win; it needs a new rising edge.
- rst_n asserted mid-round returns every output to its reset value immediately and clears all scores.

Test Plan:
- Reset, then start, then team B held for DEBOUNCE_CYCLES+4 -> state 01 then 10, thousands=010, tens/ones=0/0. Then correct -> state 00, tens/ones=0/1, thousands=010.
- In ARMED, A and C pressed on the same raw edge -> thousands=100. A later C press is ignored and thousands stays 100.
- Team A score 09, win, correct -> tens/ones=1/0. Drive A to 99, win, correct -> stays 9/9.
- Team C at 00, win, wrong -> stays 0/0. C at 10, win, wrong -> 0/9.
- 2-cycle glitch on btn_team[1] while ARMED -> state stays 01. Team press in IDLE -> state stays 00. Correct and wrong together in LOCKED -> score increments.
- Assert rst_n mid-LOCKED with nonzero scores -> outputs 00/000/0/0 asynchronously. The next round shows every team's score as 00.
